delay_ram: RTL and testbench

DELAY_RAM -- requirements
Module: delay_ram

---
 rtl/delay_ram.sv | 211 +++++++++++++++++++++
 tb/tb_delay_ram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/delay_ram.sv
// -----------------------------------------------------------------------------
// delay_ram
//
// Programmable sample delay line built on a DEPTH-entry circular buffer.
// Every cycle with cen_i high accepts one sample: d_i is written at the write
// pointer and the pointer advances. After the edge accepting sample s_n the
// output register holds s_(n-D+1), which makes the block cycle-for-cycle
// equivalent to a D-stage clock-enabled shift chain.
//
// A small FILL/RUN state machine counts the samples accepted since the last
// load or reset. vld_o rises on the edge that accepts the D-th such sample.
// While vld_o is low, d_o is forced to zero. This gating means stale buffer
// contents never reach the output, so the buffer needs no reset.
//
// Flow control: there is no ready back-pressure. cen_i acts as a qualifier
// on d_i. A sample is consumed on every rising clk_i edge where cen_i is
// high. On cycles with cen_i low, d_o, vld_o, the write pointer and the fill
// counter all hold their values.
//
// Parameters
//   WIDTH      sample width in bits
//   DEPTH      buffer entries (power of two, 2..4096)
//   INIT_DELAY delay used after reset (1..DEPTH)
//
// Ports
//   clk_i      sole clock, rising edge
//   rst_i      asynchronous active-high reset
//   cen_i      clock enable: accept d_i and advance the line
//   d_i        sample in
//   delay_i    requested delay D, sampled only while load_i is high
//   load_i     one-cycle strobe: latch delay_i and restart the fill
//   d_o        delayed sample (zero while vld_o is low)
//   vld_o      d_o holds a genuine delayed sample
//   cfg_err_o  one-cycle pulse after a load whose delay had to be clamped
// -----------------------------------------------------------------------------
module delay_ram #(
    parameter int WIDTH      = 24,
    parameter int DEPTH      = 1024,
    parameter int INIT_DELAY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cen_i,
    input  logic [WIDTH-1:0]         d_i,
    input  logic [$clog2(DEPTH):0]   delay_i,
    input  logic                     load_i,
    output logic [WIDTH-1:0]         d_o,
    output logic                     vld_o,
    output logic                     cfg_err_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   ONE    = (AW+1)'(1);
    localparam logic [AW:0]   DMAX   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   INIT_D = (AW+1)'(INIT_DELAY);
    localparam logic [AW:0]   FMAX   = '1;
    localparam logic [AW-1:0] WONE   = AW'(1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [AW:0]     fcnt_q;
    logic [AW:0]     fcnt_d;
    logic [AW:0]     dly_q;
    logic [AW:0]     dly_d;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   wptr_d;
    logic [WIDTH-1:0] dout_d;
    logic            vld_d;
    logic            cfg_err_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      load_dly;
    logic             clamp_hit;

    // -------------------------------------------------------------------------
    // Read side
    // -------------------------------------------------------------------------
    // The read address is wptr - (D-1) mod DEPTH. D lies in 1..DEPTH, so the
    // low AW bits of D taken mod DEPTH give the same result. D = DEPTH maps
    // to wptr+1, which is the oldest entry. That entry is read here, before
    // the write on this edge lands at wptr.
    assign raddr = wptr_q - dly_q[AW-1:0] + WONE;

    // With D = 1 the sample being written on this edge is itself the output.
    // For that case, bypass the memory.
    assign rd_data = (dly_q == ONE) ? d_i : mem[raddr];

    // Delay requests outside 1..DEPTH are clamped into range and flagged.
    always_comb begin
        load_dly  = delay_i;
        clamp_hit = 1'b0;
        if (delay_i == '0) begin
            load_dly  = ONE;
            clamp_hit = 1'b1;
        end else if (delay_i > DMAX) begin
            load_dly  = DMAX;
            clamp_hit = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer write (contents are deliberately not reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (cen_i && !rst_i) begin
            mem[wptr_q] <= d_i;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        dly_d     = dly_q;
        wptr_d    = wptr_q;
        dout_d    = d_o;
        vld_d     = vld_o;
        cfg_err_d = 1'b0;

        if (cen_i) begin
            wptr_d = wptr_q + WONE;
        end

        if (load_i) begin
            // A load restarts the fill from zero. If a sample arrives on the
            // same edge, that sample counts as the first one of the new fill.
            dly_d     = load_dly;
            cfg_err_d = clamp_hit;
            if (cen_i) begin
                fcnt_d = ONE;
                if (load_dly == ONE) begin
                    state_d = RUN;
                    vld_d   = 1'b1;
                    dout_d  = d_i;
                end else begin
                    state_d = FILL;
                    vld_d   = 1'b0;
                    dout_d  = '0;
                end
            end else begin
                fcnt_d  = '0;
                state_d = FILL;
                vld_d   = 1'b0;
                dout_d  = '0;
            end
        end else if (cen_i) begin
            fcnt_d = (fcnt_q == FMAX) ? fcnt_q : fcnt_q + ONE;
            unique case (state_q)
                FILL: begin
                    // In FILL the counter stays below D, so D-1 does not
                    // underflow. D >= 1 always holds.
                    if (fcnt_q >= dly_q - ONE) begin
                        state_d = RUN;
                        vld_d   = 1'b1;
                        dout_d  = rd_data;
                    end else begin
                        vld_d   = 1'b0;
                        dout_d  = '0;
                    end
                end
                RUN: begin
                    vld_d  = 1'b1;
                    dout_d = rd_data;
                end
                default: begin
                    state_d = FILL;
                    vld_d   = 1'b0;
                    dout_d  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            fcnt_q    <= '0;
            dly_q     <= INIT_D;
            wptr_q    <= '0;
            d_o       <= '0;
            vld_o     <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            dly_q     <= dly_d;
            wptr_q    <= wptr_d;
            d_o       <= dout_d;
            vld_o     <= vld_d;
            cfg_err_o <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_delay_ram.sv
// -----------------------------------------------------------------------------
// tb_delay_ram
//
// Directed plus random stimulus for delay_ram (DEPTH=16, INIT_DELAY=2).
// A reference model keeps the full history of accepted samples and the count
// of samples since the last load or reset. From these it derives the
// expected {cfg_err_o, vld_o, d_o} for each step. That triple is queued when
// the stimulus is driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_delay_ram;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int INIT  = 2;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cen;
    logic          load;
    logic [W-1:0]  d;
    logic [AW:0]   dly;
    logic [W-1:0]  d_o;
    logic          vld_o;
    logic          cfg_err_o;

    delay_ram #(
        .WIDTH      (W),
        .DEPTH      (DEPTH),
        .INIT_DELAY (INIT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cen_i     (cen),
        .d_i       (d),
        .delay_i   (dly),
        .load_i    (load),
        .d_o       (d_o),
        .vld_o     (vld_o),
        .cfg_err_o (cfg_err_o)
    );

    // -------------------------------------------------------------------------
    // Scoreboard and reference model state
    // -------------------------------------------------------------------------
    int             tests = 0;
    int             fails = 0;
    logic [W+1:0]   exp_q[$];
    logic [W-1:0]   hist[$];
    int             fill;
    int             dcur;
    logic           m_vld;
    logic [W-1:0]   m_d;

    task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got err/vld/d=%h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        fill  = 0;
        dcur  = INIT;
        m_vld = 1'b0;
        m_d   = '0;
    endtask

    // One clock step: drive on the falling edge, predict, sample #1 after rise.
    task automatic step(input string tag, input logic c, input logic [W-1:0] di,
                        input logic l, input logic [AW:0] dl);
        logic         cerr;
        logic [W+1:0] e;
        @(negedge clk);
        cen  = c;
        d    = di;
        load = l;
        dly  = dl;
        cerr = 1'b0;
        if (l) begin
            if (dl == 0)               dcur = 1;
            else if (int'(dl) > DEPTH) dcur = DEPTH;
            else                       dcur = int'(dl);
            cerr  = (dl == 0) || (int'(dl) > DEPTH);
            fill  = 0;
            m_vld = 1'b0;
            m_d   = '0;
        end
        if (c) begin
            hist.push_back(di);
            fill++;
            if (fill >= dcur) begin
                m_vld = 1'b1;
                m_d   = hist[hist.size() - dcur];
            end else begin
                m_vld = 1'b0;
                m_d   = '0;
            end
        end
        exp_q.push_back({cerr, m_vld, m_d});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {cfg_err_o, vld_o, d_o}, e);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        rst  = 1'b1;
        cen  = 1'b0;
        load = 1'b0;
        d    = '0;
        dly  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", {cfg_err_o, vld_o, d_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Initial delay of 2 after reset.
        for (int i = 1; i <= 4; i++) step("init_fill", 1'b1, W'(i), 1'b0, '0);

        // D=1: same-edge load, zero extra latency.
        step("d1_load", 1'b1, 16'h000A, 1'b1, 5'd1);
        step("d1_next", 1'b1, 16'h000B, 1'b0, '0);

        // D=4: fill, then check that gaps in cen_i hold the outputs.
        step("d4_load", 1'b1, 16'h0100, 1'b1, 5'd4);
        for (int i = 1; i < 8; i++) step("d4_fill", 1'b1, W'(16'h0100 + i), 1'b0, '0);
        step("d4_gap", 1'b1, 16'h0200, 1'b0, '0);
        step("d4_gap", 1'b0, 16'hDEAD, 1'b0, '0);
        step("d4_gap", 1'b0, 16'hBEEF, 1'b0, '0);
        step("d4_gap", 1'b1, 16'h0201, 1'b0, '0);

        // Clamped loads: 0 behaves as 1, DEPTH+5 behaves as DEPTH.
        step("clamp0_load", 1'b1, 16'h0300, 1'b1, 5'd0);
        step("clamp0_run", 1'b1, 16'h0301, 1'b0, '0);
        step("clamp0_run", 1'b1, 16'h0302, 1'b0, '0);
        step("clamphi_load", 1'b1, 16'h0400, 1'b1, 5'd21);
        for (int i = 1; i < 20; i++) step("clamphi_run", 1'b1, W'(16'h0400 + i), 1'b0, '0);

        // Full-depth delay across pointer wrap.
        step("depth_load", 1'b0, 16'h0000, 1'b1, 5'd16);
        for (int i = 0; i <= 40; i++) step("depth_run", 1'b1, W'(i), 1'b0, '0);

        // In-range load with cen_i low, then a reload in the middle of the fill.
        step("refill_load", 1'b0, 16'h0000, 1'b1, 5'd6);
        for (int i = 0; i < 3; i++) step("refill_part", 1'b1, W'(16'h0500 + i), 1'b0, '0);
        step("refill_reload", 1'b1, 16'h0600, 1'b1, 5'd3);
        for (int i = 1; i < 6; i++) step("refill_run", 1'b1, W'(16'h0600 + i), 1'b0, '0);

        // Asynchronous reset during a fill, asserted between edges.
        step("rst_mid_load", 1'b1, 16'h0700, 1'b1, 5'd5);
        step("rst_mid_fill", 1'b1, 16'h0701, 1'b0, '0);
        cen  = 1'b0;
        load = 1'b0;
        rst  = 1'b1;
        #1;
        check("rst_async", {cfg_err_o, vld_o, d_o}, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("rst_refill", 1'b1, W'(16'h0800 + i), 1'b0, '0);

        // Random mix of enables, loads and delays (including out-of-range ones).
        for (int i = 0; i < 120; i++) begin
            step("random",
                 1'($urandom_range(0, 3) != 0),
                 W'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 9) == 0),
                 AW'(0) + (AW+1)'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
